// File: rtl/pipe_pkg.sv
// pipe_pkg: shared slot-tag type, forwarding-select encoding and register width
// for the EX-stage hazard and forwarding control.
package pipe_pkg;
    localparam int REG_AW = 4;
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              mem_read;
    } stage_tag_t;
    typedef enum logic [1:0] {
        FW_REG = 2'd0,
        FW_MEM = 2'd1,
        FW_WB  = 2'd2,
        FW_WB2 = 2'd3
    } fwd_sel_t;
endpackage

// File: rtl/fwd_sel_unit.sv
// fwd_sel_unit: picks the nearest downstream slot that produces an EX source operand.
module fwd_sel_unit import pipe_pkg::*; #(
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              i_src_valid,
    input  logic              i_src_use,
    input  logic [REG_AW-1:0] i_src_rs,
    input  stage_tag_t        i_mem,
    input  stage_tag_t        i_wb,
    input  stage_tag_t        i_wb2,
    output fwd_sel_t          o_sel
);
    logic w_src_ok;
    function automatic logic hit(input stage_tag_t t, input logic [REG_AW-1:0] rs, input logic load_ok);
        return t.valid & t.reg_write & (load_ok | ~t.mem_read) & (t.rd == rs);
    endfunction
    assign w_src_ok = i_src_valid & i_src_use & ~(ZERO_REG && (i_src_rs == '0));
    // A load still in MEM has no data yet; the load-use stall keeps that case from arising.
    always_comb begin
        o_sel = !w_src_ok                      ? FW_REG :
                hit(i_mem, i_src_rs, 1'b0)     ? FW_MEM :
                hit(i_wb,  i_src_rs, 1'b1)     ? FW_WB  :
                hit(i_wb2, i_src_rs, 1'b1)     ? FW_WB2 : FW_REG;
    end
endmodule

// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl: EX-stage forwarding selects, load-use stall/bubble and a
// saturating stall counter, driven by destination tags of the EX..WB2 slots.
module ex_hazard_ctrl import pipe_pkg::*; #(
    parameter int REG_AW   = 4,
    parameter bit ZERO_REG = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              freeze,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    output logic [1:0]        sel_fw_a,
    output logic [1:0]        sel_fw_b,
    output logic              stall_id,
    output logic              bubble_ex,
    output logic [CNT_W-1:0]  stall_cnt
);
    stage_tag_t        r_ex, r_mem, r_wb, r_wb2;
    logic [REG_AW-1:0] r_ex_rs1, r_ex_rs2;
    logic              r_ex_use1, r_ex_use2;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_hazard, w_take;
    fwd_sel_t          w_sel_a, w_sel_b;

    assign w_hazard = r_ex.valid & r_ex.mem_read & r_ex.reg_write & id_valid
                    & ((id_use_rs1 & (id_rs1 == r_ex.rd)) | (id_use_rs2 & (id_rs2 == r_ex.rd)))
                    & ~(ZERO_REG && (r_ex.rd == '0));
    assign w_take    = id_valid & ~w_hazard;
    assign stall_id  = freeze | w_hazard;
    assign bubble_ex = ~freeze & w_hazard;
    assign stall_cnt = r_cnt;
    assign sel_fw_a  = w_sel_a;
    assign sel_fw_b  = w_sel_b;

    // Freeze holds every slot and the counter; a hazard is counted only when the pipe moves.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex      <= '0;
            r_mem     <= '0;
            r_wb      <= '0;
            r_wb2     <= '0;
            r_ex_rs1  <= '0;
            r_ex_rs2  <= '0;
            r_ex_use1 <= 1'b0;
            r_ex_use2 <= 1'b0;
            r_cnt     <= '0;
        end else if (!freeze) begin
            r_wb2     <= r_wb;
            r_wb      <= r_mem;
            r_mem     <= r_ex;
            r_ex      <= w_take ? stage_tag_t'{1'b1, id_rd, id_reg_write, id_mem_read} : '0;
            r_ex_rs1  <= w_take ? id_rs1 : '0;
            r_ex_rs2  <= w_take ? id_rs2 : '0;
            r_ex_use1 <= w_take & id_use_rs1;
            r_ex_use2 <= w_take & id_use_rs2;
            if (w_hazard && !(&r_cnt))
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    fwd_sel_unit #(.ZERO_REG(ZERO_REG)) u_fwd_a (
        .i_src_valid (r_ex.valid),
        .i_src_use   (r_ex_use1),
        .i_src_rs    (r_ex_rs1),
        .i_mem       (r_mem),
        .i_wb        (r_wb),
        .i_wb2       (r_wb2),
        .o_sel       (w_sel_a)
    );

    fwd_sel_unit #(.ZERO_REG(ZERO_REG)) u_fwd_b (
        .i_src_valid (r_ex.valid),
        .i_src_use   (r_ex_use2),
        .i_src_rs    (r_ex_rs2),
        .i_mem       (r_mem),
        .i_wb        (r_wb),
        .i_wb2       (r_wb2),
        .o_sel       (w_sel_b)
    );
endmodule
